// File: rtl/id_issue_buffer_pkg.sv
// Types shared by the ID/issue buffer: the decoded-entry record handed from decode to issue.
package id_issue_buffer_pkg;

   localparam int unsigned XLEN          = 32;
   localparam int unsigned TRANS_ID_BITS = 3;
   localparam int unsigned REG_ADDR_BITS = 5;

   typedef enum logic [3:0] {
      FU_NONE,
      FU_LOAD,
      FU_STORE,
      FU_ALU,
      FU_CTRL_FLOW,
      FU_MULT,
      FU_CSR
   } fu_t;

   typedef struct packed {
      logic [XLEN-1:0]          pc;
      logic [TRANS_ID_BITS-1:0] trans_id;
      fu_t                      fu;
      logic [REG_ADDR_BITS-1:0] rs1;
      logic [REG_ADDR_BITS-1:0] rs2;
      logic [REG_ADDR_BITS-1:0] rd;
      logic [XLEN-1:0]          result;
      logic                     use_imm;
      logic                     valid;
   } scoreboard_entry_t;

   typedef struct packed {
      scoreboard_entry_t sbe;
      logic [31:0]       orig_instr;
      logic              is_ctrl_flow;
   } id_entry_t;

endpackage

// File: rtl/id_issue_buffer.sv
// Multi-lane in-order ring buffer between the decoders and issue: prefix-ordered accept/ack,
// optional serialisation so a control-flow entry is always the last lane presented.
module id_issue_buffer
   import id_issue_buffer_pkg::*;
#(
   parameter int unsigned NrPorts        = 2,
   parameter int unsigned Depth          = 4,
   parameter bit          CtrlFlowSerial = 1'b1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  id_entry_t [NrPorts-1:0]    in_entry_i,
   input  logic [NrPorts-1:0]         in_valid_i,
   output logic [NrPorts-1:0]         in_ready_o,
   output id_entry_t [NrPorts-1:0]    out_entry_o,
   output logic [NrPorts-1:0]         out_valid_o,
   input  logic [NrPorts-1:0]         out_ack_i,
   output logic [$clog2(Depth+1)-1:0] occupancy_o
);

   localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW  = $clog2(Depth + 1);
   localparam int unsigned LaneW = $clog2(NrPorts + 1);

   id_entry_t [Depth-1:0] storage_q, storage_d;
   logic [PtrW-1:0]       head_q, head_d;
   logic [PtrW-1:0]       tail_q, tail_d;
   logic [CntW-1:0]       count_q, count_d;
   logic [CntW-1:0]       free;
   logic [NrPorts-1:0]    ack_hit, acc_hit;
   logic [LaneW-1:0]      n_ack, n_acc;

   function automatic logic [LaneW-1:0] lead_ones(input logic [NrPorts-1:0] v);
      logic [LaneW-1:0] n;
      logic             run;
      n   = '0;
      run = 1'b1;
      for (int i = 0; i < NrPorts; i++) begin
         run = run & v[i];
         if (run) n = n + LaneW'(1);
      end
      return n;
   endfunction

   // Wrap compares against Depth-1 explicitly so non-power-of-two depths work.
   function automatic logic [PtrW-1:0] ptr_add(input logic [PtrW-1:0] p,
                                                input logic [LaneW-1:0] n);
      logic [PtrW-1:0] r;
      r = p;
      for (int k = 0; k < NrPorts; k++) begin
         if (LaneW'(k) < n) r = (r == PtrW'(Depth - 1)) ? '0 : r + PtrW'(1);
      end
      return r;
   endfunction

   always_comb begin
      logic cf_seen;
      cf_seen     = 1'b0;
      out_entry_o = '0;
      out_valid_o = '0;
      for (int i = 0; i < NrPorts; i++) begin
         out_entry_o[i] = storage_q[ptr_add(head_q, LaneW'(i))];
         out_valid_o[i] = (int'(count_q) > i) && !(CtrlFlowSerial && cf_seen);
         cf_seen        = cf_seen | out_entry_o[i].is_ctrl_flow;
      end
   end

   always_comb begin
      ack_hit = out_ack_i & out_valid_o;
      n_ack   = lead_ones(ack_hit);
      // Same-cycle acks free space: combinational ack -> ready path.
      free    = CntW'(Depth) - count_q + CntW'(n_ack);

      in_ready_o = '0;
      for (int i = 0; i < NrPorts; i++) begin
         in_ready_o[i] = (int'(free) > i);
      end
      acc_hit = in_valid_i & in_ready_o;
      n_acc   = lead_ones(acc_hit);

      storage_d = storage_q;
      for (int i = 0; i < NrPorts; i++) begin
         if (LaneW'(i) < n_acc) storage_d[ptr_add(tail_q, LaneW'(i))] = in_entry_i[i];
      end

      head_d  = ptr_add(head_q, n_ack);
      tail_d  = ptr_add(tail_q, n_acc);
      count_d = count_q + CntW'(n_acc) - CntW'(n_ack);

      // Flush drops handshaked entries; storage keeps stale data, which count hides.
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         storage_q <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
      end else begin
         storage_q <= storage_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
      end
   end

   assign occupancy_o = count_q;

   count_within_depth: assert property (@(posedge clk_i) disable iff (!rst_ni)
      count_q <= CntW'(Depth));

endmodule

// File: tb/tb_id_issue_buffer.sv
// Directed bench for id_issue_buffer: a 2x4 serialising instance, a 2x3 instance for
// wrap-around streaming, and a 2x4 non-serialising instance for control-flow comparison.
module tb_id_issue_buffer;
   import id_issue_buffer_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic            flush_a, flush_b, flush_c;
   id_entry_t [1:0] in_entry_a, in_entry_b, in_entry_c;
   id_entry_t [1:0] out_entry_a, out_entry_b, out_entry_c;
   logic [1:0]      in_valid_a, in_valid_b, in_valid_c;
   logic [1:0]      in_ready_a, in_ready_b, in_ready_c;
   logic [1:0]      out_valid_a, out_valid_b, out_valid_c;
   logic [1:0]      out_ack_a, out_ack_b, out_ack_c;
   logic [2:0]      occ_a, occ_c;
   logic [1:0]      occ_b;

   id_issue_buffer #(.NrPorts(2), .Depth(4), .CtrlFlowSerial(1'b1)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_a),
      .in_entry_i(in_entry_a), .in_valid_i(in_valid_a), .in_ready_o(in_ready_a),
      .out_entry_o(out_entry_a), .out_valid_o(out_valid_a), .out_ack_i(out_ack_a),
      .occupancy_o(occ_a));

   id_issue_buffer #(.NrPorts(2), .Depth(3), .CtrlFlowSerial(1'b1)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_b),
      .in_entry_i(in_entry_b), .in_valid_i(in_valid_b), .in_ready_o(in_ready_b),
      .out_entry_o(out_entry_b), .out_valid_o(out_valid_b), .out_ack_i(out_ack_b),
      .occupancy_o(occ_b));

   id_issue_buffer #(.NrPorts(2), .Depth(4), .CtrlFlowSerial(1'b0)) dut_c (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_c),
      .in_entry_i(in_entry_c), .in_valid_i(in_valid_c), .in_ready_o(in_ready_c),
      .out_entry_o(out_entry_c), .out_valid_o(out_valid_c), .out_ack_i(out_ack_c),
      .occupancy_o(occ_c));

   function automatic id_entry_t mk(input logic [31:0] pc, input logic cf);
      id_entry_t e;
      e              = '0;
      e.sbe.pc       = pc;
      e.orig_instr   = pc ^ 32'h0000_0013;
      e.is_ctrl_flow = cf;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush_a = 1'b0; in_entry_a = '0; in_valid_a = '0; out_ack_a = '0;
      flush_b = 1'b0; in_entry_b = '0; in_valid_b = '0; out_ack_b = '0;
      flush_c = 1'b0; in_entry_c = '0; in_valid_c = '0; out_ack_c = '0;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      tests++; if (in_ready_a !== 2'b11) begin fails++; $display("FAIL reset_ready: got %b want 11", in_ready_a); end
      tests++; if (out_valid_a !== 2'b00) begin fails++; $display("FAIL reset_valid: got %b want 00", out_valid_a); end
      tests++; if (occ_a !== 3'd0) begin fails++; $display("FAIL reset_occ: got %0d want 0", occ_a); end
      tests++; if (out_entry_a !== '0) begin fails++; $display("FAIL reset_entry: got %h want 0", out_entry_a); end
      tests++; if (occ_b !== 2'd0) begin fails++; $display("FAIL reset_occ_b: got %0d want 0", occ_b); end
   endtask

   task automatic test_fill();
      in_entry_a[0] = mk(32'h1000, 1'b0); in_entry_a[1] = mk(32'h1004, 1'b0); in_valid_a = 2'b11;
      #1;
      tests++; if (in_ready_a !== 2'b11) begin fails++; $display("FAIL fill_ready0: got %b want 11", in_ready_a); end
      tests++; if (out_valid_a !== 2'b00) begin fails++; $display("FAIL fill_nobypass: got %b want 00", out_valid_a); end
      tick();
      in_entry_a[0] = mk(32'h1008, 1'b0); in_entry_a[1] = mk(32'h100C, 1'b0);
      tick();
      idle();
      #1;
      tests++; if (occ_a !== 3'd4) begin fails++; $display("FAIL fill_occ: got %0d want 4", occ_a); end
      tests++; if (in_ready_a !== 2'b00) begin fails++; $display("FAIL fill_full_ready: got %b want 00", in_ready_a); end
      tests++; if (out_valid_a !== 2'b11) begin fails++; $display("FAIL fill_valid: got %b want 11", out_valid_a); end
      tests++; if (out_entry_a[0].sbe.pc !== 32'h1000) begin fails++; $display("FAIL fill_lane0: got %h want 1000", out_entry_a[0].sbe.pc); end
      tests++; if (out_entry_a[1].sbe.pc !== 32'h1004) begin fails++; $display("FAIL fill_lane1: got %h want 1004", out_entry_a[1].sbe.pc); end
   endtask

   task automatic test_full_ack();
      in_entry_a[0] = mk(32'h1010, 1'b0); in_entry_a[1] = mk(32'h1014, 1'b0);
      in_valid_a = 2'b11; out_ack_a = 2'b11;
      #1;
      tests++; if (in_ready_a !== 2'b11) begin fails++; $display("FAIL fullack_ready: got %b want 11", in_ready_a); end
      tick();
      idle();
      #1;
      tests++; if (occ_a !== 3'd4) begin fails++; $display("FAIL fullack_occ: got %0d want 4", occ_a); end
      tests++; if (out_entry_a[0].sbe.pc !== 32'h1008) begin fails++; $display("FAIL fullack_lane0: got %h want 1008", out_entry_a[0].sbe.pc); end
      tests++; if (out_entry_a[1].sbe.pc !== 32'h100C) begin fails++; $display("FAIL fullack_lane1: got %h want 100c", out_entry_a[1].sbe.pc); end
   endtask

   task automatic test_gap();
      in_entry_a[0] = mk(32'h1018, 1'b0); in_entry_a[1] = mk(32'h101C, 1'b0);
      out_ack_a = 2'b10; in_valid_a = 2'b10;
      #1;
      tests++; if (in_ready_a !== 2'b00) begin fails++; $display("FAIL gap_ready: got %b want 00", in_ready_a); end
      tick();
      idle();
      #1;
      tests++; if (occ_a !== 3'd4) begin fails++; $display("FAIL gap_ack_occ: got %0d want 4", occ_a); end
      tests++; if (out_entry_a[0].sbe.pc !== 32'h1008) begin fails++; $display("FAIL gap_ack_head: got %h want 1008", out_entry_a[0].sbe.pc); end
      out_ack_a = 2'b11;
      tick();
      idle();
      #1;
      tests++; if (occ_a !== 3'd2) begin fails++; $display("FAIL drain2_occ: got %0d want 2", occ_a); end
      tests++; if (out_entry_a[0].sbe.pc !== 32'h1010) begin fails++; $display("FAIL drain2_lane0: got %h want 1010", out_entry_a[0].sbe.pc); end
      tests++; if (out_entry_a[1].sbe.pc !== 32'h1014) begin fails++; $display("FAIL drain2_lane1: got %h want 1014", out_entry_a[1].sbe.pc); end
      in_entry_a[0] = mk(32'h1018, 1'b0); in_entry_a[1] = mk(32'h101C, 1'b0); in_valid_a = 2'b10;
      #1;
      tests++; if (in_ready_a !== 2'b11) begin fails++; $display("FAIL gap_push_ready: got %b want 11", in_ready_a); end
      tick();
      idle();
      #1;
      tests++; if (occ_a !== 3'd2) begin fails++; $display("FAIL gap_push_occ: got %0d want 2", occ_a); end
      out_ack_a = 2'b11;
      tick();
      idle();
      #1;
      tests++; if (occ_a !== 3'd0) begin fails++; $display("FAIL drain0_occ: got %0d want 0", occ_a); end
      tests++; if (out_valid_a !== 2'b00) begin fails++; $display("FAIL drain0_valid: got %b want 00", out_valid_a); end
      out_ack_a = 2'b11;
      tick();
      idle();
      #1;
      tests++; if (occ_a !== 3'd0) begin fails++; $display("FAIL empty_ack_occ: got %0d want 0", occ_a); end
   endtask

   task automatic test_flush();
      in_entry_a[0] = mk(32'h2000, 1'b0); in_entry_a[1] = mk(32'h2004, 1'b0); in_valid_a = 2'b11;
      tick();
      in_entry_a[0] = mk(32'h2008, 1'b0); in_entry_a[1] = '0; in_valid_a = 2'b01;
      tick();
      idle();
      #1;
      tests++; if (occ_a !== 3'd3) begin fails++; $display("FAIL preflush_occ: got %0d want 3", occ_a); end
      flush_a = 1'b1; out_ack_a = 2'b11; in_valid_a = 2'b11;
      in_entry_a[0] = mk(32'h200C, 1'b0); in_entry_a[1] = mk(32'h2010, 1'b0);
      #1;
      tests++; if (in_ready_a !== 2'b11) begin fails++; $display("FAIL flush_ready: got %b want 11", in_ready_a); end
      tick();
      idle();
      #1;
      tests++; if (occ_a !== 3'd0) begin fails++; $display("FAIL flush_occ: got %0d want 0", occ_a); end
      tests++; if (out_valid_a !== 2'b00) begin fails++; $display("FAIL flush_valid: got %b want 00", out_valid_a); end
      in_entry_a[0] = mk(32'h2014, 1'b0); in_valid_a = 2'b01;
      #1;
      tests++; if (out_valid_a !== 2'b00) begin fails++; $display("FAIL postflush_nobypass: got %b want 00", out_valid_a); end
      tick();
      idle();
      #1;
      tests++; if (out_valid_a !== 2'b01) begin fails++; $display("FAIL postflush_valid: got %b want 01", out_valid_a); end
      tests++; if (out_entry_a[0].sbe.pc !== 32'h2014) begin fails++; $display("FAIL postflush_lane0: got %h want 2014", out_entry_a[0].sbe.pc); end
      tests++; if (occ_a !== 3'd1) begin fails++; $display("FAIL postflush_occ: got %0d want 1", occ_a); end
      out_ack_a = 2'b01;
      tick();
      idle();
   endtask

   task automatic test_ctrl_serial();
      in_entry_a[0] = mk(32'h3000, 1'b1); in_entry_a[1] = mk(32'h3004, 1'b0); in_valid_a = 2'b11;
      in_entry_c[0] = mk(32'h3000, 1'b1); in_entry_c[1] = mk(32'h3004, 1'b0); in_valid_c = 2'b11;
      tick();
      idle();
      #1;
      tests++; if (out_valid_a !== 2'b01) begin fails++; $display("FAIL cf_head_serial: got %b want 01", out_valid_a); end
      tests++; if (out_valid_c !== 2'b11) begin fails++; $display("FAIL cf_head_noserial: got %b want 11", out_valid_c); end
      out_ack_a = 2'b11; out_ack_c = 2'b11;
      tick();
      idle();
      #1;
      tests++; if (occ_a !== 3'd1) begin fails++; $display("FAIL cf_ack_hidden_occ: got %0d want 1", occ_a); end
      tests++; if (occ_c !== 3'd0) begin fails++; $display("FAIL cf_ack_noserial_occ: got %0d want 0", occ_c); end
      out_ack_a = 2'b01;
      tick();
      in_entry_a[0] = mk(32'h3008, 1'b0); in_entry_a[1] = mk(32'h300C, 1'b1); in_valid_a = 2'b11;
      in_entry_c[0] = mk(32'h3008, 1'b0); in_entry_c[1] = mk(32'h300C, 1'b1); in_valid_c = 2'b11;
      out_ack_a = 2'b00;
      tick();
      idle();
      #1;
      tests++; if (out_valid_a !== 2'b11) begin fails++; $display("FAIL cf_second_serial: got %b want 11", out_valid_a); end
      tests++; if (out_valid_c !== 2'b11) begin fails++; $display("FAIL cf_second_noserial: got %b want 11", out_valid_c); end
      tests++; if (out_entry_a[1].sbe.pc !== 32'h300C) begin fails++; $display("FAIL cf_second_lane1: got %h want 300c", out_entry_a[1].sbe.pc); end
   endtask

   task automatic test_reset_mid();
      #2 rst_n = 1'b0;
      #1;
      tests++; if (occ_a !== 3'd0) begin fails++; $display("FAIL midreset_occ: got %0d want 0", occ_a); end
      tests++; if (out_valid_a !== 2'b00) begin fails++; $display("FAIL midreset_valid: got %b want 00", out_valid_a); end
      tests++; if (in_ready_a !== 2'b11) begin fails++; $display("FAIL midreset_ready: got %b want 11", in_ready_a); end
      tests++; if (out_entry_a !== '0) begin fails++; $display("FAIL midreset_entry: got %h want 0", out_entry_a); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_wrap();
      int         pushed, popped, cnt, nacc, nack, cyc;
      logic [1:0] v, a, exp_valid, exp_ready;
      pushed = 0; popped = 0; cnt = 0; cyc = 0;
      while (cyc < 300 && popped < 20) begin
         v = 2'($urandom_range(0, 3));
         a = 2'($urandom_range(0, 3));
         for (int i = 0; i < 2; i++) begin
            if (pushed + i >= 20) v[i] = 1'b0;
            in_entry_b[i] = mk(32'h100 + 32'(4 * (pushed + i)), 1'b0);
         end
         in_valid_b = v;
         out_ack_b  = a;
         #1;
         exp_valid = {cnt > 1, cnt > 0};
         tests++; if (out_valid_b !== exp_valid) begin fails++; $display("FAIL wrap_valid cyc %0d: got %b want %b", cyc, out_valid_b, exp_valid); end
         tests++; if (int'(occ_b) !== cnt) begin fails++; $display("FAIL wrap_occ cyc %0d: got %0d want %0d", cyc, occ_b, cnt); end
         nack = 0;
         for (int i = 0; i < 2; i++) begin
            if (nack == i && a[i] && exp_valid[i]) begin
               tests++;
               if (out_entry_b[i].sbe.pc !== 32'h100 + 32'(4 * popped)) begin
                  fails++;
                  $display("FAIL wrap_order lane %0d: got %h want %h", i, out_entry_b[i].sbe.pc, 32'h100 + 32'(4 * popped));
               end
               popped++;
               nack++;
            end
         end
         exp_ready = {(3 - cnt + nack) > 1, (3 - cnt + nack) > 0};
         tests++; if (in_ready_b !== exp_ready) begin fails++; $display("FAIL wrap_ready cyc %0d: got %b want %b", cyc, in_ready_b, exp_ready); end
         nacc = 0;
         for (int i = 0; i < 2; i++) begin
            if (nacc == i && v[i] && exp_ready[i]) nacc++;
         end
         pushed += nacc;
         cnt    += nacc - nack;
         cyc++;
         tick();
      end
      idle();
      tests++; if (popped != 20) begin fails++; $display("FAIL wrap_done: got %0d want 20 entries issued", popped); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_full_ack();
      test_gap();
      test_flush();
      test_ctrl_serial();
      test_reset_mid();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
